// File: rtl/smps_pwm_ctrl.sv
// SMPS gate-drive sequencer: complementary high/low-side PWM with dead-time,
// soft-start duty ramp, period-aligned config updates and latched fault shutdown.
module smps_pwm_ctrl #(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned TS_DEFAULT = 200,
   parameter int unsigned DT         = 4,
   parameter int unsigned SS_STEP    = 10
) (
   input  logic             i_clk,
   input  logic             reset,
   input  logic             i_enable,
   input  logic             i_cfg_load,
   input  logic [CNT_W-1:0] i_ts,
   input  logic [CNT_W-1:0] i_ton,
   input  logic             i_fault,
   output logic             o_hs,
   output logic             o_ls,
   output logic             o_period_start,
   output logic             o_cfg_err,
   output logic [1:0]       o_state
);
   localparam int unsigned  W        = CNT_W + 1;
   localparam logic [W-1:0] ONE_W    = W'(1);
   localparam logic [W-1:0] DT_W     = W'(DT);
   localparam logic [W-1:0] DT2_W    = W'(2 * DT);
   localparam logic [W-1:0] TS_MIN_W = W'(2 * DT + 2);
   localparam logic [W-1:0] SS_W     = W'(SS_STEP);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SOFTSTART = 2'd1,
      RUN       = 2'd2,
      FAULT     = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] ts_q, ts_d;
   logic [CNT_W-1:0] tgt_q, tgt_d;
   logic [CNT_W-1:0] ss_q, ss_d;
   logic [CNT_W-1:0] pts_q, pts_d;
   logic [CNT_W-1:0] pton_q, pton_d;
   logic             pvld_q, pvld_d;
   logic             hs_q, hs_d;
   logic             ls_q, ls_d;
   logic             ps_q, ps_d;
   logic             err_q, err_d;

   logic             running, boundary, load_ok;
   logic [W-1:0]     cnt_w, ts_w, ton_cur, ton_lim, ton_eff, ss_sum;
   logic [CNT_W-1:0] nxt_tgt;

   assign running  = (state_q == SOFTSTART) || (state_q == RUN);
   assign cnt_w    = {1'b0, count_q};
   assign ts_w     = {1'b0, ts_q};
   assign ton_cur  = (state_q == SOFTSTART) ? {1'b0, ss_q} : {1'b0, tgt_q};
   assign ton_lim  = ts_w - DT2_W;
   assign ton_eff  = (ton_cur < ton_lim) ? ton_cur : ton_lim;
   assign boundary = running && (cnt_w == ts_w - ONE_W);
   assign load_ok  = i_cfg_load && ({1'b0, i_ts} >= TS_MIN_W);
   // Soft-start step is clamped against the target that takes effect at this boundary.
   assign nxt_tgt  = pvld_q ? pton_q : tgt_q;
   assign ss_sum   = {1'b0, ss_q} + SS_W;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ts_d    = ts_q;
      tgt_d   = tgt_q;
      ss_d    = ss_q;
      pts_d   = pts_q;
      pton_d  = pton_q;
      pvld_d  = pvld_q;
      hs_d    = 1'b0;
      ls_d    = 1'b0;
      ps_d    = 1'b0;
      err_d   = i_cfg_load && !load_ok;

      unique case (state_q)
         IDLE: begin
            count_d = '0;
            ss_d    = '0;
            if (load_ok) begin
               ts_d   = i_ts;
               tgt_d  = i_ton;
               pvld_d = 1'b0;
            end else if (pvld_q) begin
               ts_d   = pts_q;
               tgt_d  = pton_q;
               pvld_d = 1'b0;
            end
            if (i_fault)
               state_d = FAULT;
            else if (i_enable)
               state_d = SOFTSTART;
         end

         SOFTSTART, RUN: begin
            if (load_ok) begin
               pts_d  = i_ts;
               pton_d = i_ton;
               pvld_d = 1'b1;
            end
            if (i_fault) begin
               state_d = FAULT;
               count_d = '0;
            end else if (!i_enable) begin
               state_d = IDLE;
               count_d = '0;
            end else begin
               hs_d = cnt_w < ton_eff;
               ls_d = (cnt_w >= ton_eff + DT_W) && (cnt_w < ts_w - DT_W);
               ps_d = (count_q == '0);
               if (boundary) begin
                  count_d = '0;
                  if (pvld_q) begin
                     ts_d  = pts_q;
                     tgt_d = pton_q;
                     if (!load_ok)
                        pvld_d = 1'b0;
                  end
                  if (state_q == SOFTSTART) begin
                     ss_d = (ss_sum < {1'b0, nxt_tgt}) ? ss_sum[CNT_W-1:0] : nxt_tgt;
                     if (ss_sum >= {1'b0, nxt_tgt})
                        state_d = RUN;
                  end
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end

         FAULT: begin
            count_d = '0;
            if (!i_enable && !i_fault)
               state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
         ts_q    <= CNT_W'(TS_DEFAULT);
         tgt_q   <= CNT_W'(TS_DEFAULT / 2);
         ss_q    <= '0;
         pts_q   <= '0;
         pton_q  <= '0;
         pvld_q  <= 1'b0;
         hs_q    <= 1'b0;
         ls_q    <= 1'b0;
         ps_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ts_q    <= ts_d;
         tgt_q   <= tgt_d;
         ss_q    <= ss_d;
         pts_q   <= pts_d;
         pton_q  <= pton_d;
         pvld_q  <= pvld_d;
         hs_q    <= hs_d;
         ls_q    <= ls_d;
         ps_q    <= ps_d;
         err_q   <= err_d;
      end
   end

   // Fault is the only input allowed to gate the drives without a register stage.
   assign o_hs           = hs_q & ~i_fault;
   assign o_ls           = ls_q & ~i_fault;
   assign o_period_start = ps_q;
   assign o_cfg_err      = err_q;
   assign o_state        = state_q;

endmodule

// File: tb/tb_smps_pwm_ctrl.sv
// Self-checking bench for smps_pwm_ctrl: period-level reference model of gate
// windows, soft-start ramp, config timing and fault/enable/reset behaviour.
module tb_smps_pwm_ctrl;
   localparam int CNT_W      = 8;
   localparam int TS_DEFAULT = 200;
   localparam int DT         = 4;
   localparam int SS_STEP    = 10;

   logic             i_clk = 1'b0;
   logic             reset;
   logic             i_enable;
   logic             i_cfg_load;
   logic [CNT_W-1:0] i_ts;
   logic [CNT_W-1:0] i_ton;
   logic             i_fault;
   logic             o_hs;
   logic             o_ls;
   logic             o_period_start;
   logic             o_cfg_err;
   logic [1:0]       o_state;

   int checks = 0;
   int errors = 0;
   int m_len, m_hs, m_hs_last, m_ls, m_ls_first, m_ls_last, m_both, m_state;
   int cfg_ts, cfg_ton;

   smps_pwm_ctrl #(
      .CNT_W(CNT_W),
      .TS_DEFAULT(TS_DEFAULT),
      .DT(DT),
      .SS_STEP(SS_STEP)
   ) dut (
      .i_clk(i_clk),
      .reset(reset),
      .i_enable(i_enable),
      .i_cfg_load(i_cfg_load),
      .i_ts(i_ts),
      .i_ton(i_ton),
      .i_fault(i_fault),
      .o_hs(o_hs),
      .o_ls(o_ls),
      .o_period_start(o_period_start),
      .o_cfg_err(o_cfg_err),
      .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   function automatic int eff_on(input int ts, input int ton);
      return (ton < ts - 2 * DT) ? ton : ts - 2 * DT;
   endfunction

   task automatic step();
      @(negedge i_clk);
   endtask

   task automatic sync_ps();
      int n = 0;
      while (o_period_start !== 1'b1 && n < 600) begin
         step();
         n++;
      end
      if (o_period_start !== 1'b1) begin
         checks++; errors++;
         $display("FAIL sync_ps: got no period start, required one within 600 cycles");
      end
   endtask

   // Records one whole period, index 0 being the o_period_start cycle.
   task automatic measure();
      int idx = 0;
      m_hs = 0; m_hs_last = -1; m_ls = 0; m_ls_first = -1; m_ls_last = -1; m_both = 0;
      sync_ps();
      m_state = int'(o_state);
      do begin
         if (o_hs === 1'b1) begin m_hs++; m_hs_last = idx; end
         if (o_ls === 1'b1) begin
            if (m_ls_first < 0) m_ls_first = idx;
            m_ls_last = idx;
            m_ls++;
         end
         if (o_hs === 1'b1 && o_ls === 1'b1) m_both++;
         step();
         idx++;
      end while (o_period_start !== 1'b1 && idx < 600);
      m_len = idx;
   endtask

   task automatic test_reset();
      repeat (3) step();
      checks++; if (o_hs !== 1'b0) begin errors++; $display("FAIL reset_hs: got %b required 0", o_hs); end
      checks++; if (o_ls !== 1'b0) begin errors++; $display("FAIL reset_ls: got %b required 0", o_ls); end
      checks++; if (o_period_start !== 1'b0) begin errors++; $display("FAIL reset_ps: got %b required 0", o_period_start); end
      checks++; if (o_cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", o_cfg_err); end
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", o_state); end
      reset = 1'b1;
      repeat (3) step();
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL idle_state: got %0d required 0", o_state); end
      cfg_ts = TS_DEFAULT; cfg_ton = TS_DEFAULT / 2;
   endtask

   task automatic test_softstart();
      i_enable = 1'b1;
      for (int p = 1; p <= 12; p++) begin
         int ramp, e_on, e_st;
         ramp = SS_STEP * (p - 1);
         e_on = eff_on(cfg_ts, (ramp < cfg_ton) ? ramp : cfg_ton);
         e_st = (ramp >= cfg_ton) ? 2 : 1;
         measure();
         checks++; if (m_len != cfg_ts) begin errors++; $display("FAIL ss_len p%0d: got %0d required %0d", p, m_len, cfg_ts); end
         checks++; if (m_hs != e_on) begin errors++; $display("FAIL ss_hs p%0d: got %0d required %0d", p, m_hs, e_on); end
         checks++; if (m_state != e_st) begin errors++; $display("FAIL ss_state p%0d: got %0d required %0d", p, m_state, e_st); end
      end
   endtask

   task automatic test_run_window();
      measure();
      checks++; if (m_len != 200) begin errors++; $display("FAIL run_len: got %0d required 200", m_len); end
      checks++; if (m_hs != 100 || m_hs_last != 99) begin errors++; $display("FAIL run_hs: got %0d/last %0d required 100/last 99", m_hs, m_hs_last); end
      checks++; if (m_ls_first != 104) begin errors++; $display("FAIL run_ls_first: got %0d required 104", m_ls_first); end
      checks++; if (m_ls_last != 195) begin errors++; $display("FAIL run_ls_last: got %0d required 195", m_ls_last); end
      checks++; if (m_ls != 92) begin errors++; $display("FAIL run_ls_cnt: got %0d required 92", m_ls); end
      checks++; if (m_both != 0) begin errors++; $display("FAIL run_overlap: got %0d required 0", m_both); end
      checks++; if (m_state != 2) begin errors++; $display("FAIL run_state: got %0d required 2", m_state); end
   endtask

   task automatic test_cfg_midperiod();
      int n = 0;
      sync_ps();
      repeat (50) begin step(); n++; end
      i_ts = 8'd100; i_ton = 8'd30; i_cfg_load = 1'b1;
      step(); n++;
      i_cfg_load = 1'b0;
      while (o_period_start !== 1'b1 && n < 600) begin step(); n++; end
      checks++; if (n != 200) begin errors++; $display("FAIL cfg_cur_len: got %0d required 200", n); end
      cfg_ts = 100; cfg_ton = 30;
      measure();
      checks++; if (m_len != 100) begin errors++; $display("FAIL cfg_new_len: got %0d required 100", m_len); end
      checks++; if (m_hs != 30) begin errors++; $display("FAIL cfg_new_hs: got %0d required 30", m_hs); end
      checks++; if (m_ls_first != 34 || m_ls_last != 95) begin errors++; $display("FAIL cfg_new_ls: got %0d..%0d required 34..95", m_ls_first, m_ls_last); end
      i_ts = 8'd9; i_ton = 8'd5; i_cfg_load = 1'b1;
      step();
      i_cfg_load = 1'b0;
      checks++; if (o_cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse: got %b required 1", o_cfg_err); end
      step();
      checks++; if (o_cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_end: got %b required 0", o_cfg_err); end
      for (int k = 0; k < 2; k++) begin
         measure();
         checks++; if (m_len != 100 || m_hs != 30) begin errors++; $display("FAIL cfg_rejected p%0d: got len %0d hs %0d required 100/30", k, m_len, m_hs); end
      end
   endtask

   task automatic test_boundary_load();
      sync_ps();
      repeat (cfg_ts - 2) step();
      i_ts = 8'd60; i_ton = 8'd20; i_cfg_load = 1'b1;
      step();
      i_cfg_load = 1'b0;
      measure();
      checks++; if (m_len != 100 || m_hs != 30) begin errors++; $display("FAIL bnd_old: got len %0d hs %0d required 100/30", m_len, m_hs); end
      measure();
      checks++; if (m_len != 60 || m_hs != 20) begin errors++; $display("FAIL bnd_new: got len %0d hs %0d required 60/20", m_len, m_hs); end
      checks++; if (m_ls_first != 24 || m_ls_last != 55) begin errors++; $display("FAIL bnd_new_ls: got %0d..%0d required 24..55", m_ls_first, m_ls_last); end
      cfg_ts = 60; cfg_ton = 20;
   endtask

   task automatic test_clamp();
      sync_ps();
      i_ts = 8'd200; i_ton = 8'd250; i_cfg_load = 1'b1;
      step();
      i_cfg_load = 1'b0;
      measure();
      checks++; if (m_len != 200) begin errors++; $display("FAIL clamp_len: got %0d required 200", m_len); end
      checks++; if (m_hs != 192 || m_hs_last != 191) begin errors++; $display("FAIL clamp_hs: got %0d/last %0d required 192/last 191", m_hs, m_hs_last); end
      checks++; if (m_ls != 0) begin errors++; $display("FAIL clamp_ls: got %0d required 0", m_ls); end
      cfg_ts = 200; cfg_ton = 250;
   endtask

   task automatic test_random_cfg();
      for (int it = 0; it < 8; it++) begin
         int ts, ton, e_hs, e_ls;
         logic bad;
         bad = ($urandom_range(0, 3) == 0);
         ts  = bad ? int'($urandom_range(0, 2 * DT + 1)) : int'($urandom_range(2 * DT + 2, 255));
         ton = int'($urandom_range(0, 255));
         sync_ps();
         i_ts = 8'(ts); i_ton = 8'(ton); i_cfg_load = 1'b1;
         step();
         i_cfg_load = 1'b0;
         checks++; if (o_cfg_err !== bad) begin errors++; $display("FAIL rnd_err it%0d: got %b required %b (ts %0d)", it, o_cfg_err, bad, ts); end
         step();
         checks++; if (o_cfg_err !== 1'b0) begin errors++; $display("FAIL rnd_err_end it%0d: got %b required 0", it, o_cfg_err); end
         if (!bad) begin cfg_ts = ts; cfg_ton = ton; end
         e_hs = eff_on(cfg_ts, cfg_ton);
         e_ls = cfg_ts - 2 * DT - e_hs;
         measure();
         checks++; if (m_len != cfg_ts) begin errors++; $display("FAIL rnd_len it%0d: got %0d required %0d", it, m_len, cfg_ts); end
         checks++; if (m_hs != e_hs) begin errors++; $display("FAIL rnd_hs it%0d: got %0d required %0d", it, m_hs, e_hs); end
         checks++; if (m_ls != e_ls) begin errors++; $display("FAIL rnd_ls it%0d: got %0d required %0d", it, m_ls, e_ls); end
         if (e_ls > 0) begin
            checks++; if (m_ls_first != e_hs + DT || m_ls_last != cfg_ts - DT - 1) begin
               errors++; $display("FAIL rnd_ls_win it%0d: got %0d..%0d required %0d..%0d", it, m_ls_first, m_ls_last, e_hs + DT, cfg_ts - DT - 1);
            end
         end
         checks++; if (m_both != 0 || m_state != 2) begin errors++; $display("FAIL rnd_misc it%0d: got overlap %0d state %0d required 0/2", it, m_both, m_state); end
      end
   endtask

   task automatic test_fault();
      for (int k = 0; k < 2; k++) begin
         int n = 0;
         while (((k == 0) ? o_hs : o_ls) !== 1'b1 && n < 600) begin step(); n++; end
         checks++; if (n >= 600) begin errors++; $display("FAIL flt_wait k%0d: got no active drive, required one within 600 cycles", k); end
         i_fault = 1'b1;
         #1;
         checks++; if (o_hs !== 1'b0 || o_ls !== 1'b0) begin errors++; $display("FAIL flt_comb k%0d: got hs %b ls %b required 0/0", k, o_hs, o_ls); end
         step();
         checks++; if (o_state !== 2'd3) begin errors++; $display("FAIL flt_state k%0d: got %0d required 3", k, o_state); end
         i_fault = 1'b0;
         repeat (3) step();
         checks++; if (o_state !== 2'd3 || o_hs !== 1'b0 || o_ls !== 1'b0) begin errors++; $display("FAIL flt_latched k%0d: got state %0d hs %b ls %b required 3/0/0", k, o_state, o_hs, o_ls); end
         i_enable = 1'b0;
         step();
         checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL flt_idle k%0d: got %0d required 0", k, o_state); end
         i_ts = 8'd200; i_ton = 8'd100; i_cfg_load = 1'b1;
         step();
         i_cfg_load = 1'b0;
         cfg_ts = 200; cfg_ton = 100;
         i_enable = 1'b1;
         for (int p = 1; p <= 2; p++) begin
            measure();
            checks++; if (m_len != 200 || m_hs != SS_STEP * (p - 1) || m_state != 1) begin
               errors++; $display("FAIL flt_restart k%0d p%0d: got len %0d hs %0d state %0d required 200/%0d/1", k, p, m_len, m_hs, m_state, SS_STEP * (p - 1));
            end
         end
      end
   endtask

   task automatic test_enable_and_reset();
      i_enable = 1'b0;
      step();
      i_ts = 8'd40; i_ton = 8'd30; i_cfg_load = 1'b1;
      step();
      i_cfg_load = 1'b0;
      cfg_ts = 40; cfg_ton = 30;
      i_enable = 1'b1;
      measure();
      repeat (5) step();
      i_enable = 1'b0;
      step();
      checks++; if (o_hs !== 1'b0 || o_ls !== 1'b0 || o_period_start !== 1'b0) begin errors++; $display("FAIL en_drop_out: got hs %b ls %b ps %b required 0/0/0", o_hs, o_ls, o_period_start); end
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL en_drop_state: got %0d required 0", o_state); end
      repeat (3) step();
      i_enable = 1'b1;
      for (int p = 1; p <= 4; p++) begin
         int ramp, e_st;
         ramp = SS_STEP * (p - 1);
         e_st = (ramp >= cfg_ton) ? 2 : 1;
         measure();
         checks++; if (m_len != 40 || m_hs != ((ramp < cfg_ton) ? ramp : cfg_ton) || m_state != e_st) begin
            errors++; $display("FAIL en_restart p%0d: got len %0d hs %0d state %0d required 40/%0d/%0d", p, m_len, m_hs, m_state, (ramp < cfg_ton) ? ramp : cfg_ton, e_st);
         end
      end
      repeat (3) step();
      reset = 1'b0;
      #1;
      checks++; if (o_hs !== 1'b0 || o_ls !== 1'b0 || o_period_start !== 1'b0 || o_cfg_err !== 1'b0) begin
         errors++; $display("FAIL rst_mid_out: got hs %b ls %b ps %b err %b required all 0", o_hs, o_ls, o_period_start, o_cfg_err);
      end
      checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d required 0", o_state); end
      repeat (2) step();
      reset = 1'b1;
      cfg_ts = TS_DEFAULT; cfg_ton = TS_DEFAULT / 2;
      measure();
      checks++; if (m_len != 200 || m_hs != 0 || m_state != 1) begin errors++; $display("FAIL rst_restart: got len %0d hs %0d state %0d required 200/0/1", m_len, m_hs, m_state); end
   endtask

   initial begin
      reset = 1'b1;
      i_enable = 1'b0; i_cfg_load = 1'b0; i_fault = 1'b0;
      i_ts = '0; i_ton = '0;
      #2 reset = 1'b0;
      test_reset();
      test_softstart();
      test_run_window();
      test_cfg_midperiod();
      test_boundary_load();
      test_clamp();
      test_random_cfg();
      test_fault();
      test_enable_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
